// File: rtl/spike_rate_encoder_pkg.sv
// Shared types and helpers for the rate-coded spike encoder: LFSR taps,
// encoder state encoding, a constant clog2 and the per-lane seed rule.
package spike_rate_encoder_pkg;

  // Galois right-shift taps for x^16+x^14+x^13+x^11+1 (maximal length 65535).
  localparam logic [15:0] LFSR16_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENCODE = 2'd1,
    ST_REST   = 2'd2
  } enc_state_t;

  // Ceiling log2, usable in parameter expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // Lane i starts from base ^ (i+1); an all-zero seed would lock the LFSR, so it becomes 1.
  function automatic logic [15:0] lane_seed(input logic [15:0] base, input int lane);
    logic [15:0] s;
    s = base ^ 16'(lane + 1);
    if (s == 16'h0000) begin
      s = 16'h0001;
    end
    return s;
  endfunction

  // One Galois step: shift right, fold the taps in when the bit shifted out was 1.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    logic [15:0] n;
    n = {1'b0, s[15:1]};
    if (s[0]) begin
      n = n ^ LFSR16_TAPS;
    end
    return n;
  endfunction

endpackage

// File: rtl/spike_rate_encoder_if.sv
// Sample-in / spikes-out bundle between a pixel source and the encoder.
// The master side offers samples and watches the spike lanes; the slave is the encoder.
interface spike_rate_encoder_if #(
  parameter int NUM_INPUTS  = 4,
  parameter int PIXEL_WIDTH = 8
);

  logic [NUM_INPUTS*PIXEL_WIDTH-1:0] pixel_data;
  logic                              pixel_valid;
  logic                              pixel_ready;
  logic [NUM_INPUTS-1:0]             spike_out;
  logic                              busy;
  logic                              window_done;

  modport master (
    output pixel_data,
    output pixel_valid,
    input  pixel_ready,
    input  spike_out,
    input  busy,
    input  window_done
  );

  modport slave (
    input  pixel_data,
    input  pixel_valid,
    output pixel_ready,
    output spike_out,
    output busy,
    output window_done
  );

endinterface

// File: rtl/spike_rate_encoder_lfsr16.sv
// 16-bit Galois LFSR that steps only when enabled and reloads its seed on reset.
// Only the low OUT_WIDTH bits are exported since that is all the comparator needs.
module spike_rate_encoder_lfsr16
  import spike_rate_encoder_pkg::*;
#(
  parameter logic [15:0] SEED      = 16'h0001,
  parameter int          OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic [OUT_WIDTH-1:0] value
);

  localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] state;

  // Advance one Galois step per enabled cycle; hold otherwise so the sequence resumes where it left off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
    end else if (en) begin
      state <= lfsr16_next(state);
    end
  end

  assign value = state[OUT_WIDTH-1:0];

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate encoder: latches one sample of NUM_INPUTS pixels, then for WINDOW timesteps
// fires lane i with probability pix_i / 2^PIXEL_WIDTH using a private LFSR per lane,
// then stays silent for REST_CYCLES timesteps before accepting the next sample.
module spike_rate_encoder
  import spike_rate_encoder_pkg::*;
#(
  parameter int          NUM_INPUTS  = 4,
  parameter int          PIXEL_WIDTH = 8,
  parameter int          WINDOW      = 255,
  parameter int          REST_CYCLES = 5,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input logic                 clk,
  input logic                 rst,
  spike_rate_encoder_if.slave bus
);

  localparam int STEP_W = clog2(WINDOW + 1);
  localparam int REST_W = (REST_CYCLES > 0) ? clog2(REST_CYCLES + 1) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WINDOW - 1);
  localparam logic [REST_W-1:0] LAST_REST = REST_W'((REST_CYCLES > 0) ? (REST_CYCLES - 1) : 0);
  localparam logic [PIXEL_WIDTH-1:0] PIX_MAX = {PIXEL_WIDTH{1'b1}};

  if ((PIXEL_WIDTH < 1) || (PIXEL_WIDTH > 16)) begin : g_bad_pixel_width
    $error("spike_rate_encoder: PIXEL_WIDTH must be in 1..16");
  end

  if (WINDOW < 1) begin : g_bad_window
    $error("spike_rate_encoder: WINDOW must be at least 1");
  end

  enc_state_t state;
  enc_state_t state_next;

  logic [STEP_W-1:0] step;
  logic [REST_W-1:0] rest_cnt;

  logic [NUM_INPUTS*PIXEL_WIDTH-1:0] pix_reg;
  logic [NUM_INPUTS*PIXEL_WIDTH-1:0] pix_sel;
  logic [PIXEL_WIDTH-1:0]            pix_lane;
  logic [PIXEL_WIDTH-1:0]            lfsr_rnd [NUM_INPUTS];

  logic [NUM_INPUTS-1:0] spike_next;
  logic [NUM_INPUTS-1:0] spike_reg;

  logic accept;
  logic enc_next;
  logic last_step;
  logic last_rest;
  logic ready_int;
  logic busy_int;
  logic done_int;

  assign last_step = (step == LAST_STEP);
  assign last_rest = (rest_cnt == LAST_REST);

  // State register; reset returns to IDLE immediately, discarding any partial window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus status outputs; enc_next marks edges that load a spike cycle and step the LFSRs.
  always_comb begin
    state_next = state;
    ready_int  = 1'b0;
    busy_int   = 1'b0;
    done_int   = 1'b0;
    accept     = 1'b0;
    enc_next   = 1'b0;
    case (state)
      ST_IDLE: begin
        ready_int = 1'b1;
        if (bus.pixel_valid) begin
          accept     = 1'b1;
          enc_next   = 1'b1;
          state_next = ST_ENCODE;
        end
      end
      ST_ENCODE: begin
        busy_int = 1'b1;
        if (last_step) begin
          done_int   = 1'b1;
          state_next = (REST_CYCLES == 0) ? ST_IDLE : ST_REST;
        end else begin
          enc_next = 1'b1;
        end
      end
      ST_REST: begin
        busy_int = 1'b1;
        if (last_rest) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Step counter names the current ENCODE timestep and is zero whenever not encoding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step <= '0;
    end else if ((state == ST_ENCODE) && !last_step) begin
      step <= step + STEP_W'(1);
    end else begin
      step <= '0;
    end
  end

  // Rest counter times the silent gap; unused when REST_CYCLES is zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rest_cnt <= '0;
    end else if ((state == ST_REST) && !last_rest) begin
      rest_cnt <= rest_cnt + REST_W'(1);
    end else begin
      rest_cnt <= '0;
    end
  end

  // Capture the sample at the accepting edge so the source may change data right after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_reg <= '0;
    end else if (accept) begin
      pix_reg <= bus.pixel_data;
    end
  end

  // Per-lane comparator for the spike cycle being loaded; the accepting edge uses live data since pix_reg is not loaded yet.
  always_comb begin
    pix_sel    = accept ? bus.pixel_data : pix_reg;
    pix_lane   = '0;
    spike_next = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      pix_lane = pix_sel[i*PIXEL_WIDTH +: PIXEL_WIDTH];
      if (enc_next) begin
        spike_next[i] = (pix_lane == PIX_MAX) ? 1'b1 : (lfsr_rnd[i] < pix_lane);
      end
    end
  end

  // Spike lanes come straight from flops so the network sees clean, glitch-free inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_reg <= '0;
    end else begin
      spike_reg <= spike_next;
    end
  end

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_lane
    spike_rate_encoder_lfsr16 #(
      .SEED      (lane_seed(SEED, g)),
      .OUT_WIDTH (PIXEL_WIDTH)
    ) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .en    (enc_next),
      .value (lfsr_rnd[g])
    );
  end

  assign bus.pixel_ready = ready_int;
  assign bus.busy        = busy_int;
  assign bus.window_done = done_int;
  assign bus.spike_out   = spike_reg;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Bench for spike_rate_encoder: a default instance (WINDOW=255, REST_CYCLES=5) and a
// fast instance (WINDOW=1, REST_CYCLES=0). A bit-accurate LFSR model fills a queue of
// expected spike vectors at each accepted sample; outputs are popped and compared.
module tb_spike_rate_encoder;

  localparam int WIN_A  = 255;
  localparam int REST_A = 5;

  logic clk;
  logic rst_a;
  logic rst_b;

  int checks;
  int failures;

  logic [15:0] mdl_a [4];
  logic [15:0] mdl_b [4];
  logic [3:0]  exp_q [$];
  logic [3:0]  exp_b_q [$];
  int          obs_cnt [4];
  int          exp_cnt [4];

  spike_rate_encoder_if #(.NUM_INPUTS(4), .PIXEL_WIDTH(8)) bus_a ();
  spike_rate_encoder_if #(.NUM_INPUTS(4), .PIXEL_WIDTH(8)) bus_b ();

  spike_rate_encoder #(
    .NUM_INPUTS  (4),
    .PIXEL_WIDTH (8),
    .WINDOW      (WIN_A),
    .REST_CYCLES (REST_A),
    .SEED        (16'hACE1)
  ) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  spike_rate_encoder #(
    .NUM_INPUTS  (4),
    .PIXEL_WIDTH (8),
    .WINDOW      (1),
    .REST_CYCLES (0),
    .SEED        (16'hACE1)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference LFSR step: right shift, XOR taps B400 when the outgoing bit is 1.
  function automatic logic [15:0] lfsrNext(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  function automatic logic [15:0] seedOf(input int lane);
    logic [15:0] s;
    s = 16'hACE1 ^ 16'(lane + 1);
    if (s == 16'h0000) s = 16'h0001;
    return s;
  endfunction

  function automatic logic spikeOf(input logic [7:0] pix, input logic [15:0] s);
    if (pix == 8'hFF) return 1'b1;
    return (s[7:0] < pix);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic reseedA();
    for (int i = 0; i < 4; i++) mdl_a[i] = seedOf(i);
  endtask

  // Offer one sample to instance A, push its expected trace, then check the window and rest.
  // hold_valid keeps valid high with random data throughout; abort_step >= 0 resets mid-window.
  task automatic applyStimulus(input logic [31:0] data, input bit hold_valid, input int abort_step);
    int guard;
    int ready_low;
    logic [3:0] exp_vec;
    logic [7:0] pix;
    guard = 0;
    while (bus_a.pixel_ready !== 1'b1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) begin
      checkOutput("a_accept_timeout", 32'd0, 32'd1);
      return;
    end
    bus_a.pixel_data  = data;
    bus_a.pixel_valid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    for (int k = 0; k < WIN_A; k++) begin
      exp_vec = '0;
      for (int i = 0; i < 4; i++) begin
        pix = data[i*8 +: 8];
        exp_vec[i] = spikeOf(pix, mdl_a[i]);
        mdl_a[i] = lfsrNext(mdl_a[i]);
        exp_cnt[i] += int'(exp_vec[i]);
      end
      exp_q.push_back(exp_vec);
    end
    @(negedge clk);
    if (hold_valid) bus_a.pixel_data = $urandom;
    else bus_a.pixel_valid = 1'b0;
    ready_low = 0;
    for (int i = 0; i < 4; i++) obs_cnt[i] = 0;
    for (int k = 0; k < WIN_A; k++) begin
      if (k > 0) @(negedge clk);
      if (exp_q.size() == 0) begin
        checkOutput("a_queue_empty", 32'd0, 32'd1);
        exp_vec = '0;
      end else begin
        exp_vec = exp_q.pop_front();
      end
      checkOutput("a_spike", 32'(bus_a.spike_out), 32'(exp_vec));
      checkOutput("a_window_done", 32'(bus_a.window_done), 32'(k == WIN_A - 1));
      checkOutput("a_busy_encode", 32'(bus_a.busy), 32'd1);
      if (bus_a.pixel_ready === 1'b0) ready_low++;
      for (int i = 0; i < 4; i++) obs_cnt[i] += int'(bus_a.spike_out[i]);
      if (hold_valid) bus_a.pixel_data = $urandom;
      if (k == abort_step) begin
        #2 rst_a = 1'b1;
        #1;
        checkOutput("a_async_spike", 32'(bus_a.spike_out), 32'd0);
        checkOutput("a_async_ready", 32'(bus_a.pixel_ready), 32'd1);
        checkOutput("a_async_busy", 32'(bus_a.busy), 32'd0);
        checkOutput("a_async_done", 32'(bus_a.window_done), 32'd0);
        reseedA();
        exp_q.delete();
        bus_a.pixel_valid = 1'b0;
        @(negedge clk);
        rst_a = 1'b0;
        return;
      end
    end
    for (int r = 0; r < REST_A; r++) begin
      @(negedge clk);
      checkOutput("a_rest_spike", 32'(bus_a.spike_out), 32'd0);
      checkOutput("a_rest_done", 32'(bus_a.window_done), 32'd0);
      checkOutput("a_rest_busy", 32'(bus_a.busy), 32'd1);
      if (bus_a.pixel_ready === 1'b0) ready_low++;
      if (hold_valid) bus_a.pixel_data = $urandom;
    end
    @(negedge clk);
    checkOutput("a_ready_low_cycles", 32'(ready_low), 32'(WIN_A + REST_A));
    checkOutput("a_ready_back", 32'(bus_a.pixel_ready), 32'd1);
    checkOutput("a_busy_idle", 32'(bus_a.busy), 32'd0);
    for (int i = 0; i < 4; i++) checkOutput("a_lane_count", 32'(obs_cnt[i]), 32'(exp_cnt[i]));
    bus_a.pixel_valid = 1'b0;
  endtask

  // Instance B: valid held high with fresh data every cycle; expects an accept every other cycle.
  task automatic runFastInstance();
    bit exp_idle;
    logic [3:0] exp_vec;
    logic [31:0] data;
    exp_idle = 1'b1;
    bus_b.pixel_valid = 1'b1;
    for (int c = 0; c < 24; c++) begin
      checkOutput("b_ready", 32'(bus_b.pixel_ready), 32'(exp_idle));
      checkOutput("b_busy", 32'(bus_b.busy), 32'(!exp_idle));
      checkOutput("b_window_done", 32'(bus_b.window_done), 32'(!exp_idle));
      if (!exp_idle) begin
        if (exp_b_q.size() == 0) begin
          checkOutput("b_queue_empty", 32'd0, 32'd1);
          exp_vec = '0;
        end else begin
          exp_vec = exp_b_q.pop_front();
        end
        checkOutput("b_spike", 32'(bus_b.spike_out), 32'(exp_vec));
      end else begin
        checkOutput("b_spike_idle", 32'(bus_b.spike_out), 32'd0);
      end
      data = $urandom;
      bus_b.pixel_data = data;
      if (exp_idle) begin
        for (int i = 0; i < 4; i++) begin
          exp_vec[i] = spikeOf(data[i*8 +: 8], mdl_b[i]);
          mdl_b[i] = lfsrNext(mdl_b[i]);
        end
        exp_b_q.push_back(exp_vec);
      end
      exp_idle = !exp_idle;
      @(negedge clk);
    end
    bus_b.pixel_valid = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.pixel_valid = 1'b0;
    bus_a.pixel_data  = '0;
    bus_b.pixel_valid = 1'b0;
    bus_b.pixel_data  = '0;
    reseedA();
    for (int i = 0; i < 4; i++) mdl_b[i] = seedOf(i);
    repeat (2) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("a_rst_ready", 32'(bus_a.pixel_ready), 32'd1);
    checkOutput("a_rst_spike", 32'(bus_a.spike_out), 32'd0);
    checkOutput("a_rst_busy", 32'(bus_a.busy), 32'd0);
    checkOutput("a_rst_done", 32'(bus_a.window_done), 32'd0);
    checkOutput("b_rst_ready", 32'(bus_b.pixel_ready), 32'd1);
    checkOutput("b_rst_busy", 32'(bus_b.busy), 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);

    $display("[TB] zero pixels");
    applyStimulus(32'h0000_0000, 1'b0, -1);
    for (int i = 0; i < 4; i++) checkOutput("zero_count", 32'(obs_cnt[i]), 32'd0);

    $display("[TB] saturated pixels");
    applyStimulus(32'hFFFF_FFFF, 1'b0, -1);
    for (int i = 0; i < 4; i++) checkOutput("sat_count", 32'(obs_cnt[i]), 32'd255);

    $display("[TB] mid values with valid held high");
    applyStimulus(32'h1020_4080, 1'b1, -1);
    $display("[TB] mid counts lane0..3 = %0d %0d %0d %0d", obs_cnt[0], obs_cnt[1], obs_cnt[2], obs_cnt[3]);
    applyStimulus(32'h7F01_FE33, 1'b1, -1);
    applyStimulus(32'hA5C3_5A0F, 1'b0, -1);

    $display("[TB] reset mid-window then replay from seeds");
    rst_a = 1'b1;
    reseedA();
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    applyStimulus(32'h1020_4080, 1'b0, 100);
    applyStimulus(32'h1020_4080, 1'b0, -1);

    $display("[TB] WINDOW=1 REST_CYCLES=0 back-to-back");
    runFastInstance();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
